// File: rtl/hdmi_cfg_pkg.sv
// Shared types and constants for the HDMI transmitter configuration sequencer.
package hdmi_cfg_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  // Number of register writes in the configuration table.
  localparam int NUM_REGS = 12;

  // Width of the table index carried on cfg_index.
  localparam int IDX_W = 4;

  // {register address, register data} pairs, written in index order.
  localparam logic [15:0] CFG_TABLE [NUM_REGS] = '{
    16'h4110, 16'h9803, 16'h9AE0, 16'h9C30,
    16'h9D61, 16'hA2A4, 16'hA3A4, 16'hE0D0,
    16'hF900, 16'h1500, 16'h1630, 16'h1746
  };

  // Bits needed to hold values 0 .. max_val-1, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/hdmi_config_sequencer_rom.sv
// Combinational lookup of the configuration table; unused addresses read as zero.
module hdmi_config_rom
  import hdmi_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] i_addr,
  output logic [15:0]      o_data
);

  // Table lookup with out-of-range guard.
  always_comb begin
    o_data = 16'h0000;
    if (i_addr < IDX_W'(NUM_REGS)) begin
      o_data = CFG_TABLE[i_addr];
    end
  end

endmodule

// File: rtl/hdmi_config_sequencer.sv
// Walks the HDMI transmitter register table, issuing one I2C write per entry,
// retrying on NACK or timeout, and reporting overall success or failure.
module hdmi_config_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter int          PWRUP_CYCLES   = 10000,
  parameter int          GAP_CYCLES     = 64,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          MAX_RETRY      = 3,
  parameter logic [7:0]  SLAVE_ADDR     = 8'h72
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_cfg,
  input  logic             i2c_busy,
  input  logic             i2c_done,
  input  logic             i2c_nack,
  output logic             i2c_start,
  output logic [23:0]      i2c_data,
  output logic [IDX_W-1:0] cfg_index,
  output logic             cfg_done,
  output logic             cfg_error
);

  // One down-counter serves power-up wait, inter-transaction gap and timeout,
  // so it is sized for the largest of the three.
  localparam int CNT_MAX = (PWRUP_CYCLES > TIMEOUT_CYCLES)
                         ? ((PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES)
                         : ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES);
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam int RTY_W   = cnt_width(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t             r_state;
  state_t             w_next;
  state_t             r_gap_tgt;
  logic [CNT_W-1:0]   r_cnt;
  logic [RTY_W-1:0]   r_retry;
  logic [IDX_W-1:0]   r_index;
  logic [23:0]        r_data;
  logic [15:0]        w_rom_data;

  logic w_cnt_zero;
  logic w_in_wait;
  logic w_ok;
  logic w_fail;
  logic w_can_retry;
  logic w_last;
  logic w_restart;
  logic w_issue;

  hdmi_config_rom u_rom (
    .i_addr (r_index),
    .o_data (w_rom_data)
  );

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_in_wait   = (r_state == ST_WAIT_DONE);
  // A completed transaction always takes precedence over a simultaneous timeout.
  assign w_ok        = w_in_wait && i2c_done && !i2c_nack;
  assign w_fail      = w_in_wait && (i2c_done ? i2c_nack : w_cnt_zero);
  assign w_can_retry = (r_retry < RTY_MAX);
  assign w_last      = (r_index == LAST_IDX);
  assign w_restart   = ((r_state == ST_DONE) || (r_state == ST_ERROR)) && start_cfg;
  assign w_issue     = (r_state == ST_ISSUE) && !i2c_busy;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_PWRUP;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_PWRUP:     if (w_cnt_zero) w_next = ST_LOAD;
      ST_LOAD:      w_next = ST_ISSUE;
      ST_ISSUE:     if (w_issue) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (w_ok) begin
          w_next = w_last ? ST_DONE : ST_GAP;
        end else if (w_fail) begin
          w_next = w_can_retry ? ST_GAP : ST_ERROR;
        end
      end
      ST_GAP:       if (w_cnt_zero) w_next = r_gap_tgt;
      ST_DONE:      if (start_cfg) w_next = ST_LOAD;
      ST_ERROR:     if (start_cfg) w_next = ST_LOAD;
      default:      w_next = ST_PWRUP;
    endcase
  end

  // Output decode; the start request is combinational so it is seen in the ISSUE cycle.
  always_comb begin
    i2c_start = w_issue;
    i2c_data  = r_data;
    cfg_index = r_index;
    cfg_done  = (r_state == ST_DONE);
    cfg_error = (r_state == ST_ERROR);
  end

  // Shared wait counter: reloads on entry to GAP or on issue, otherwise saturating decrement.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= PWR_LOAD;
    end else if ((w_next == ST_GAP) && (r_state != ST_GAP)) begin
      r_cnt <= GAP_LOAD;
    end else if (w_issue) begin
      r_cnt <= TMO_LOAD;
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Transaction word, table index, retry count and post-gap target.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data    <= 24'h0;
      r_index   <= '0;
      r_retry   <= '0;
      r_gap_tgt <= ST_LOAD;
    end else begin
      if (r_state == ST_LOAD) begin
        r_data <= {SLAVE_ADDR, w_rom_data};
      end
      if (w_restart) begin
        r_index <= '0;
        r_retry <= '0;
      end else if (w_ok) begin
        r_retry <= '0;
        if (!w_last) begin
          r_index   <= r_index + 1'b1;
          r_gap_tgt <= ST_LOAD;
        end
      end else if (w_fail && w_can_retry) begin
        r_retry   <= r_retry + 1'b1;
        r_gap_tgt <= ST_ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Directed bench for hdmi_config_sequencer with a behavioural I2C master model.
module tb_hdmi_config_sequencer;

  localparam logic [15:0] TBL [12] = '{
    16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
    16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'h1746
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_cfg = 1'b0;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        i2c_start;
  logic [23:0] i2c_data;
  logic [3:0]  cfg_index;
  logic        cfg_done;
  logic        cfg_error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rel = 0;

  // Start log: word and 1-based capture cycle of every request.
  logic [23:0] st_data [$];
  int          st_cyc  [$];

  // Responder behaviour per table entry.
  int nack_plan   [12];
  bit silent_plan [12];
  int resp_delay = 20;
  int spur_req = 0;
  int spur_ack = 0;

  bit pend = 1'b0;
  bit pend_nack = 1'b0;
  int cd = 0;

  hdmi_config_sequencer #(
    .PWRUP_CYCLES   (10),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (50),
    .MAX_RETRY      (3),
    .SLAVE_ADDR     (8'h72)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_cfg (start_cfg),
    .i2c_busy  (i2c_busy),
    .i2c_done  (i2c_done),
    .i2c_nack  (i2c_nack),
    .i2c_start (i2c_start),
    .i2c_data  (i2c_data),
    .cfg_index (cfg_index),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lookup(input logic [15:0] d);
    for (int i = 0; i < 12; i++) if (d == TBL[i]) return i;
    return -1;
  endfunction

  // I2C master model: answers each request resp_delay clocks later.
  always @(negedge clk) begin : i2c_model
    int idx;
    if (!reset_n) begin
      pend     = 1'b0;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
    end else begin
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (pend) begin
        if (cd == 0) begin
          i2c_done = 1'b1;
          i2c_nack = pend_nack;
          pend     = 1'b0;
        end else begin
          cd = cd - 1;
        end
      end else if (spur_req != spur_ack) begin
        i2c_done = 1'b1;
        spur_ack = spur_req;
      end
      if (i2c_start) begin
        idx = lookup(i2c_data[15:0]);
        st_data.push_back(i2c_data);
        st_cyc.push_back(cyc + 1);
        if (idx < 0 || !silent_plan[idx]) begin
          pend      = 1'b1;
          cd        = resp_delay - 1;
          pend_nack = 1'b0;
          if (idx >= 0 && nack_plan[idx] > 0) begin
            pend_nack = 1'b1;
            if (nack_plan[idx] < 99) nack_plan[idx] = nack_plan[idx] - 1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_starts(input string tag, input int n, input int max);
    int k = 0;
    while (st_data.size() < n && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(st_data.size() >= n), 32'd1);
  endtask

  task automatic wait_end(input string tag, input int max);
    int k = 0;
    while (!(cfg_done || cfg_error) && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(cfg_done || cfg_error), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk) start_cfg = 1'b1;
    @(negedge clk) start_cfg = 1'b0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 12; i++) begin
      nack_plan[i]   = 0;
      silent_plan[i] = 1'b0;
    end
    st_data.delete();
    st_cyc.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, 32'(i2c_start), 32'd0);
    chk({tag, "_data"},  32'(i2c_data),  32'h0);
    chk({tag, "_index"}, 32'(cfg_index), 32'd0);
    chk({tag, "_done"},  32'(cfg_done),  32'd0);
    chk({tag, "_error"}, 32'(cfg_error), 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    clear_all();
    reset_n = 1'b0;
    tick(3);
    chk_reset_outputs("reset");

    // Clean run from power-up.
    reset_n = 1'b1;
    rel = cyc;
    wait_end("clean_end", 2000);
    chk("clean_done_cycle", 32'(cyc - rel + 1), 32'd319);
    chk("clean_first_start_cycle", 32'(st_cyc[0] - rel), 32'd12);
    chk("clean_start_spacing", 32'(st_cyc[1] - st_cyc[0]), 32'd26);
    chk("clean_start_count", 32'(st_data.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("clean_data_%0d", i), 32'(st_data[i]), 32'({8'h72, TBL[i]}));
    chk("clean_last_data", 32'(st_data[11]), 32'h721746);
    chk("clean_done", 32'(cfg_done), 32'd1);
    chk("clean_error", 32'(cfg_error), 32'd0);
    chk("clean_index", 32'(cfg_index), 32'd11);

    // Restart from DONE, then a start_cfg mid-run that must be ignored.
    clear_all();
    pulse_start();
    chk("restart_done_drops", 32'(cfg_done), 32'd0);
    chk("restart_index", 32'(cfg_index), 32'd0);
    tick(1);
    chk("restart_start", 32'(i2c_start), 32'd1);
    chk("restart_data", 32'(i2c_data), 32'h724110);
    wait_starts("mid_reach", 3, 200);
    tick(5);
    pulse_start();
    wait_end("mid_end", 1000);
    chk("mid_start_count", 32'(st_data.size()), 32'd12);
    chk("mid_data_3", 32'(st_data[3]), 32'h729C30);
    chk("mid_done", 32'(cfg_done), 32'd1);

    // NACK retries: entry 3 twice, entry 7 three times (retry count must reset between).
    clear_all();
    nack_plan[3] = 2;
    nack_plan[7] = 3;
    pulse_start();
    wait_end("nack_end", 2000);
    chk("nack_start_count", 32'(st_data.size()), 32'd17);
    for (int i = 3; i < 6; i++)
      chk($sformatf("nack_e3_data_%0d", i), 32'(st_data[i]), 32'h729C30);
    chk("nack_after_e3", 32'(st_data[6]), 32'h729D61);
    for (int i = 9; i < 13; i++)
      chk($sformatf("nack_e7_data_%0d", i), 32'(st_data[i]), 32'h72E0D0);
    chk("nack_retry_spacing", 32'(st_cyc[4] - st_cyc[3]), 32'd25);
    chk("nack_done", 32'(cfg_done), 32'd1);
    chk("nack_error", 32'(cfg_error), 32'd0);

    // Retry exhaustion on entry 5.
    clear_all();
    nack_plan[5] = 99;
    pulse_start();
    wait_end("exh_end", 2000);
    tick(200);
    chk("exh_start_count", 32'(st_data.size()), 32'd9);
    for (int i = 5; i < 9; i++)
      chk($sformatf("exh_data_%0d", i), 32'(st_data[i]), 32'h72A2A4);
    chk("exh_error", 32'(cfg_error), 32'd1);
    chk("exh_done", 32'(cfg_done), 32'd0);
    chk("exh_index", 32'(cfg_index), 32'd5);

    // Timeout: entry 0 never answered; restart is taken from ERROR.
    clear_all();
    silent_plan[0] = 1'b1;
    pulse_start();
    chk("tmo_error_drops", 32'(cfg_error), 32'd0);
    wait_end("tmo_end", 1000);
    chk("tmo_start_count", 32'(st_data.size()), 32'd4);
    chk("tmo_data_3", 32'(st_data[3]), 32'h724110);
    // 50 clocks waiting, 4 gap clocks, then the reissue cycle.
    chk("tmo_retry_spacing", 32'(st_cyc[1] - st_cyc[0]), 32'd55);
    chk("tmo_error", 32'(cfg_error), 32'd1);
    chk("tmo_index", 32'(cfg_index), 32'd0);

    // Done arriving in the same cycle the timeout expires counts as success.
    clear_all();
    resp_delay = 50;
    pulse_start();
    wait_end("tie_end", 2000);
    chk("tie_done", 32'(cfg_done), 32'd1);
    chk("tie_start_count", 32'(st_data.size()), 32'd12);
    resp_delay = 20;

    // Busy holds off the request; a stray done while in ISSUE is ignored.
    clear_all();
    i2c_busy = 1'b1;
    pulse_start();
    tick(4);
    spur_req++;
    tick(2);
    chk("busy_no_start", 32'(i2c_start), 32'd0);
    chk("busy_index", 32'(cfg_index), 32'd0);
    chk("busy_no_log", 32'(st_data.size()), 32'd0);
    @(posedge clk);
    #1 i2c_busy = 1'b0;
    @(negedge clk);
    chk("busy_release_start", 32'(i2c_start), 32'd1);
    chk("busy_release_data", 32'(i2c_data), 32'h724110);

    // Reset while waiting on entry 2.
    wait_starts("rst_reach", 3, 200);
    tick(5);
    reset_n = 1'b0;
    tick(1);
    chk_reset_outputs("midrst");
    tick(2);
    clear_all();
    reset_n = 1'b1;
    rel = cyc;
    wait_starts("rst_restart", 1, 100);
    chk("rst_first_start_cycle", 32'(st_cyc[0] - rel), 32'd12);
    chk("rst_first_data", 32'(st_data[0]), 32'h724110);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
